adder_seq_ctrl: RTL
===================

Name: adder_seq_ctrl

Overview:
Sequencer/arbiter that shares one N-bit chunk adder ({cout,sum} = a + b + cin) between two requesters and evaluates W = N*K-bit additions over K cycles, least-significant chunk first, with a carry register between chunks. Sits between operand producers and a result consumer. Each side uses a valid/ready handshake. Replaces K parallel N-bit adders where area matters more than latency.

Parameters:
N, 4, chunk adder width in bits (>=1)
K, 2, chunks per operand (>=1); operand width W = N*K

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  W  requester 0 operand A
req0_b  in  W  requester 0 operand B
req0_cin  in  1  requester 0 carry-in
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 operation accepted this cycle
req1_a  in  W  requester 1 operand A
req1_b  in  W  requester 1 operand B
req1_cin  in  1  requester 1 carry-in
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_sum  out  W  W-bit sum
res_cout  out  1  final carry-out
res_id  out  1  requester that owns the result (0/1)
busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk). Synchronous, active-high reset. On reset: state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, chunk index=0, carry=0, last_grant=1 (requester 0 wins first tie).
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration:
  - req0_ready and req1_ready are combinational. At most one is high, and only in IDLE.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted (round-robin).
  - None valid: stay in IDLE.
- IDLE, on grant:
  - Register A, B and cin of the granted requester.
  - Set res_id and last_grant to the granted requester. Set index=0 and carry=cin.
  - Go to RUN.
- RUN, per cycle for index i:
  - {c, s} = A[i*N +: N] + B[i*N +: N] + carry, computed at N+1 bits.
  - Write s into res_sum[i*N +: N]. Set carry=c and i=i+1.
  - After chunk K-1: set res_cout=c, go to DONE.
  - RUN lasts exactly K cycles.
- DONE:
  - res_valid=1. res_sum, res_cout and res_id stay stable until res_ready=1.
  - On the cycle with res_valid && res_ready: go to IDLE, res_valid=0.
  - No new request is accepted in that same cycle. The earliest next accept is the following cycle.
- Latency: accept at cycle t -> res_valid first high at t+K+1. Throughput is one operation per K+2 cycles with res_ready held high.
- Arithmetic: modulo 2^W. Overflow appears only in res_cout.
- res_sum bits from the previous operation may stay visible during RUN. Consumers sample only when res_valid=1.
- Requester inputs are ignored outside the acceptance cycle. Changing or dropping req*_valid while not ready is legal.
- Reset mid-operation (RUN or DONE): the operation is discarded with no result and no handshake, and all state returns to reset values.
- K=1: RUN is a single cycle.

Test Plan:
1. N=4, K=2. req0: a=0x3C, b=0x0F, cin=1 -> accept cycle t; res_valid at t+3 with res_sum=0x4C, res_cout=0, res_id=0.
2. req1: a=0xFF, b=0x01, cin=0 -> res_sum=0x00, res_cout=1, res_id=1. Checks carry propagation across the chunk boundary.
3. Both requesters valid continuously after reset -> grants alternate 0,1,0,1. Each req*_ready pulses one cycle per grant. Results arrive in grant order with matching res_id.
4. res_ready held low 5 cycles in DONE -> res_valid, res_sum, res_cout and res_id stay stable; req0_ready=req1_ready=0 throughout. Release -> IDLE next cycle, next grant the cycle after.
5. reset asserted during the first RUN cycle -> next cycle state IDLE, res_valid=0, res_sum=0, busy=0. The next grant with both requesters valid goes to req0.
6. Randomised-value sweep, N=4, K=3, 1000 operations with random valid and res_ready -> every result equals (a+b+cin) mod 2^12 with correct carry-out. No lost or duplicated operations.

Source files
------------

// File: rtl/adder_seq_ctrl_if.sv
// Requester/consumer handshake bundle for adder_seq_ctrl.
// slave = sequencer side, master = requesters and result consumer.
interface adder_seq_ctrl_if #(
  parameter int unsigned W = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output res_valid, res_sum, res_cout, res_id,
    input  res_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  res_valid, res_sum, res_cout, res_id,
    output res_ready
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Two-requester sequencer sharing one N-bit chunk adder; a W = N*K bit
// addition runs over K cycles, LS chunk first, carry held between chunks.
module adder_seq_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned K = 2
) (
  input  logic              clk,
  input  logic              reset,
  adder_seq_ctrl_if.slave   bus,
  output logic              busy
);
  localparam int unsigned W     = N * K;
  localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [W-1:0]     sum_q;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             cout_q;
  logic             id_q;
  logic             last_grant;
  logic             valid_q;
  logic             busy_q;

  logic             grant;
  logic             grant_id;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             sel_cin;
  logic [N:0]       chunk;

  // Round-robin arbitration; only meaningful while IDLE
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant    = 1'b1;
        grant_id = ~last_grant;
      end else if (bus.req0_valid) begin
        grant    = 1'b1;
      end else if (bus.req1_valid) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant && !grant_id;
  assign bus.req1_ready = grant && grant_id;

  assign sel_a   = grant_id ? bus.req1_a   : bus.req0_a;
  assign sel_b   = grant_id ? bus.req1_b   : bus.req0_b;
  assign sel_cin = grant_id ? bus.req1_cin : bus.req0_cin;

  // Operands shift right each RUN cycle so the active chunk is always the low N bits
  assign chunk = (N+1)'(op_a[N-1:0]) + (N+1)'(op_b[N-1:0]) + (N+1)'(carry);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      sum_q      <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      cout_q     <= 1'b0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            carry      <= sel_cin;
            id_q       <= grant_id;
            last_grant <= grant_id;
            idx        <= '0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_q[idx*N +: N] <= chunk[N-1:0];
          carry             <= chunk[N];
          op_a              <= op_a >> N;
          op_b              <= op_b >> N;
          idx               <= idx + 1'b1;
          if (idx == IDX_W'(K - 1)) begin
            cout_q  <= chunk[N];
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.res_valid = valid_q;
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = id_q;
  assign busy          = busy_q;
endmodule
